// File: rtl/psram_ctrl.sv
// Single-word HyperBus controller for the GW1NR-9C embedded PSRAM.
// One DQ byte per clk; psram_ck runs at clk/2 while CS# is low.
module psram_ctrl #(
  parameter int INIT_CYCLES = 12150,
  parameter int LATENCY     = 3,
  parameter int RD_DELAY    = 2,
  parameter int RECOVERY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        init_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [21:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        psram_cs_n,
  output logic        psram_ck,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  input  logic [7:0]  dq_in,
  output logic        rwds_out,
  output logic        rwds_oe
);

  localparam int LAT_CYCLES = 4 * LATENCY + 8;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] LAT_LAST  = 16'(LAT_CYCLES - 1);
  localparam logic [15:0] RDW_LAST  = 16'(RD_DELAY - 1);
  localparam logic [15:0] REC_LAST  = 16'(RECOVERY - 1);
  localparam logic [15:0] CMD_LAST  = 16'd5;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CMD,
    S_LAT,
    S_WR,
    S_RDW,
    S_RD,
    S_REC
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [47:0] ca_sh;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic [7:0]  rd_hi;
  logic [47:0] ca_req;

  assign ca_req = {~req_write, 1'b0, 1'b1, 10'b0, req_addr[21:3],
                   13'b0, req_addr[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      cnt        <= '0;
      ca_sh      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_hi      <= '0;
      init_done  <= 1'b0;
      req_ready  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      psram_cs_n <= 1'b1;
      psram_ck   <= 1'b0;
      dq_out     <= '0;
      dq_oe      <= 1'b0;
      rwds_out   <= 1'b0;
      rwds_oe    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        S_INIT: begin
          if (cnt == INIT_LAST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            state      <= S_CMD;
            cnt        <= '0;
            req_ready  <= 1'b0;
            wr_q       <= req_write;
            wdata_q    <= req_wdata;
            be_q       <= req_be;
            ca_sh      <= {ca_req[39:0], 8'h00};
            psram_cs_n <= 1'b0;
            psram_ck   <= 1'b1;
            dq_oe      <= 1'b1;
            dq_out     <= ca_req[47:40];
          end
        end
        S_CMD: begin
          psram_ck <= ~psram_ck;
          if (cnt == CMD_LAST) begin
            state  <= S_LAT;
            cnt    <= '0;
            dq_oe  <= 1'b0;
            dq_out <= '0;
          end else begin
            cnt    <= cnt + 16'd1;
            dq_out <= ca_sh[47:40];
            ca_sh  <= {ca_sh[39:0], 8'h00};
          end
        end
        S_LAT: begin
          psram_ck <= ~psram_ck;
          if (cnt == LAT_LAST) begin
            cnt <= '0;
            if (wr_q) begin
              state    <= S_WR;
              dq_oe    <= 1'b1;
              rwds_oe  <= 1'b1;
              dq_out   <= wdata_q[15:8];
              rwds_out <= ~be_q[1];
            end else begin
              state <= S_RDW;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WR: begin
          if (cnt == 16'd1) begin
            state      <= S_REC;
            cnt        <= '0;
            psram_cs_n <= 1'b1;
            psram_ck   <= 1'b0;
            dq_oe      <= 1'b0;
            rwds_oe    <= 1'b0;
            dq_out     <= '0;
            rwds_out   <= 1'b0;
          end else begin
            cnt      <= cnt + 16'd1;
            psram_ck <= ~psram_ck;
            dq_out   <= wdata_q[7:0];
            rwds_out <= ~be_q[0];
          end
        end
        S_RDW: begin
          psram_ck <= ~psram_ck;
          if (cnt == RDW_LAST) begin
            state <= S_RD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RD: begin
          if (cnt == 16'd0) begin
            rd_hi    <= dq_in;
            cnt      <= 16'd1;
            psram_ck <= ~psram_ck;
          end else begin
            // rd_data only changes once the full word is in hand
            rd_data    <= {rd_hi, dq_in};
            rd_valid   <= 1'b1;
            state      <= S_REC;
            cnt        <= '0;
            psram_cs_n <= 1'b1;
            psram_ck   <= 1'b0;
          end
        end
        S_REC: begin
          if (cnt == REC_LAST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= S_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_ctrl.sv
// Bench for psram_ctrl: PSRAM device model on the bus side,
// word-level reference memory on the request side.
module tb_psram_ctrl;

  localparam int INIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        psram_cs_n;
  logic        psram_ck;
  logic [7:0]  dq_out;
  logic        dq_oe;
  logic [7:0]  dq_in;
  logic        rwds_out;
  logic        rwds_oe;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [int];
  logic [15:0] dev_mem [int];
  logic [15:0] last_rd;
  int          pool [$];

  psram_ctrl #(.INIT_CYCLES(INIT)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .psram_cs_n(psram_cs_n), .psram_ck(psram_ck),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
    .rwds_out(rwds_out), .rwds_oe(rwds_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_get(input logic [15:0] m [int],
                                          input int a);
    return m.exists(a) ? m[a] : 16'h0000;
  endfunction

  // Checks the idle/INIT bus state for INIT cycles after reset release.
  task automatic release_and_wait();
    reset = 1'b0;
    for (int k = 1; k <= INIT; k++) begin
      @(negedge clk);
      dq_in = 8'($urandom);
      chk($sformatf("init_done@%0d", k), init_done, k == INIT);
      chk($sformatf("init_ready@%0d", k), req_ready, k == INIT);
      chk($sformatf("init_cs@%0d", k), psram_cs_n, 1'b1);
      chk($sformatf("init_ck@%0d", k), psram_ck, 1'b0);
      chk($sformatf("init_rdv@%0d", k), rd_valid, 1'b0);
    end
  endtask

  task automatic txn(input logic w, input logic [21:0] addr,
                     input logic [15:0] wd, input logic [1:0] be,
                     input bit hold, input int abort_at);
    int          last_act;
    int          fin;
    int          waitc;
    logic [47:0] ca;
    logic [7:0]  seen [6];
    logic [15:0] exp_rd;
    logic [15:0] dv;
    int          dev_addr;
    bit          dev_w;
    bit          act;
    last_act = w ? 28 : 30;
    fin      = w ? 33 : 35;
    ca = (48'(!w) << 47) | (48'd1 << 45) |
         (48'(addr >> 3) << 16) | 48'(addr % 8);
    exp_rd   = mem_get(ref_mem, int'(addr));
    dev_w    = 1'b0;
    dev_addr = 0;
    dv       = 16'h0;
    req_write = w;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk("handshake_wait", req_ready, 1'b1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int n = 1; n <= fin; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = hold;
      if (n == abort_at) begin
        reset = 1'b1;
        req_valid = 1'b0;
        return;
      end
      act = (n <= last_act);
      if (n <= 6) seen[n-1] = dq_out;
      if (n == 6) begin
        dev_w    = !seen[0][7];
        dev_addr = int'({seen[1][2:0], seen[2], seen[3], seen[5][2:0]});
        dv       = mem_get(dev_mem, dev_addr);
      end
      if (n == 29 && !dev_w) dq_in = dv[15:8];
      else if (n == 30 && !dev_w) dq_in = dv[7:0];
      else dq_in = 8'($urandom);
      if (dev_w && dq_oe && rwds_oe && !rwds_out) begin
        if (n == 27) dv[15:8] = dq_out;
        if (n == 28) dv[7:0] = dq_out;
      end
      chk($sformatf("cs_n@%0d", n), psram_cs_n, !act);
      chk($sformatf("ck@%0d", n), psram_ck, act ? (n % 2) : 0);
      if (psram_cs_n) chk($sformatf("ck_idle@%0d", n), psram_ck, 1'b0);
      chk($sformatf("dq_oe@%0d", n), dq_oe,
          (n <= 6) || (w && (n == 27 || n == 28)));
      chk($sformatf("rwds_oe@%0d", n), rwds_oe,
          w && (n == 27 || n == 28));
      if (n <= 6)
        chk($sformatf("ca_byte@%0d", n), dq_out,
            (ca >> (8 * (6 - n))) & 48'hff);
      if (w && n == 27) begin
        chk("wr_hi", dq_out, wd[15:8]);
        chk("rwds_hi", rwds_out, !be[1]);
      end
      if (w && n == 28) begin
        chk("wr_lo", dq_out, wd[7:0]);
        chk("rwds_lo", rwds_out, !be[0]);
      end
      chk($sformatf("rd_valid@%0d", n), rd_valid, !w && n == 31);
      if (!w && n == 31) chk("rd_data", rd_data, exp_rd);
      chk($sformatf("ready@%0d", n), req_ready, n == fin);
    end
    if (dev_w) dev_mem[dev_addr] = dv;
    if (w) begin
      dv = mem_get(ref_mem, int'(addr));
      if (be[1]) dv[15:8] = wd[15:8];
      if (be[0]) dv[7:0] = wd[7:0];
      ref_mem[int'(addr)] = dv;
      chk("dev_mem", mem_get(dev_mem, int'(addr)), dv);
      chk("rd_hold", rd_data, last_rd);
      pool.push_back(int'(addr));
    end else begin
      last_rd = exp_rd;
    end
  endtask

  initial begin
    logic        w;
    logic [21:0] a;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    dq_in     = '0;
    last_rd   = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", psram_cs_n, 1'b1);
    chk("rst_ck", psram_ck, 1'b0);
    chk("rst_oe", {dq_oe, rwds_oe}, 2'b00);
    chk("rst_out", {dq_out, rwds_out}, 9'h0);
    chk("rst_ready", {req_ready, init_done}, 2'b00);
    chk("rst_rd", {rd_valid, rd_data}, 17'h0);
    release_and_wait();

    txn(1'b1, 22'h2ABCDE, 16'hA55A, 2'b11, 1'b0, 0);
    txn(1'b1, 22'h001234, 16'hBEEF, 2'b01, 1'b0, 0);
    dev_mem[1] = 16'h1234;
    ref_mem[1] = 16'h1234;
    txn(1'b0, 22'h000001, 16'h0000, 2'b00, 1'b0, 0);
    txn(1'b1, 22'h155555, 16'hC3D2, 2'b10, 1'b1, 0);
    txn(1'b1, 22'h155555, 16'hC3D2, 2'b10, 1'b0, 0);
    txn(1'b0, 22'h2ABCDE, 16'h0000, 2'b00, 1'b1, 0);
    txn(1'b0, 22'h2ABCDE, 16'h0000, 2'b00, 1'b0, 0);
    txn(1'b0, 22'h001234, 16'h0000, 2'b00, 1'b0, 0);

    for (int i = 0; i < 14; i++) begin
      w = 1'($urandom);
      if (pool.size() > 0 && $urandom_range(0, 2) != 0)
        a = 22'(pool[$urandom_range(0, pool.size() - 1)]);
      else
        a = 22'($urandom);
      txn(w, a, 16'($urandom), 2'($urandom), 1'b0, 0);
    end

    txn(1'b0, 22'h000001, 16'h0000, 2'b00, 1'b0, 15);
    @(negedge clk);
    chk("abort_cs", psram_cs_n, 1'b1);
    chk("abort_oe", dq_oe, 1'b0);
    chk("abort_ck", psram_ck, 1'b0);
    chk("abort_rdv", rd_valid, 1'b0);
    chk("abort_rdata", rd_data, 16'h0);
    chk("abort_ready", {req_ready, init_done}, 2'b00);
    last_rd = 16'h0;
    release_and_wait();
    txn(1'b0, 22'h000001, 16'h0000, 2'b00, 1'b0, 0);
    txn(1'b1, 22'h3FFFFF, 16'h0FF0, 2'b11, 1'b0, 0);
    txn(1'b0, 22'h3FFFFF, 16'h0000, 2'b00, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psram_ctrl.md
Name: psram_ctrl

Overview:
- Single-word HyperRAM controller for the GW1NR-9C embedded 64 Mbit PSRAM, running on the 81 MHz PLL output clock.
- Converts a valid/ready word request (22-bit word address, 16-bit data, byte enables) into a HyperBus transaction: CS#, CK, 8-bit DQ and RWDS.
- DQ runs one byte per clk cycle, so it is DDR relative to psram_ck (clk/2).
- Pad tri-state buffers and ck/data phase alignment are done at top level by I/O cells and are out of scope here.

Parameters:
- INIT_CYCLES, 12150, clk cycles held in INIT after reset (150 us at 81 MHz).
- LATENCY, 3, initial latency in psram_ck cycles (fixed 2x mode). LAT state lasts 4*LATENCY+8 clk cycles.
- RD_DELAY, 2, clk cycles between end of LAT and capture of the first read byte.
- RECOVERY, 4, clk cycles CS# held high after a transaction (tRWR).

Ports:
- clk  in  1  81 MHz system clock
- reset  in  1  synchronous, active-high reset
- init_done  out  1  high once INIT completes; stays high until reset
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  22  word address
- req_wdata  in  16  write data
- req_be  in  2  byte enables, bit1 = [15:8]
- rd_valid  out  1  one-cycle pulse carrying read data
- rd_data  out  16  read data; holds its value until the next read
- psram_cs_n  out  1  chip select, active low
- psram_ck  out  1  memory clock
- dq_out  out  8  DQ drive value
- dq_oe  out  1  DQ output enable
- dq_in  in  8  DQ pad input
- rwds_out  out  1  RWDS drive value
- rwds_oe  out  1  RWDS output enable

Behaviour:
- Reset values:
  - psram_cs_n=1, psram_ck=0.
  - dq_oe=0, rwds_oe=0, dq_out=0, rwds_out=0.
  - req_ready=0, init_done=0, rd_valid=0, rd_data=0.
  - State = INIT with the counter cleared.
- Reset mid-transaction: all of the above take effect on the next edge, including CS# high, and the full INIT wait is repeated.
- All outputs are registered.
- States: INIT -> IDLE -> CMD -> LAT -> (WR | RDW -> RD) -> REC -> IDLE.
- INIT: counts INIT_CYCLES, then enters IDLE and sets init_done.
- IDLE: req_ready=1. On handshake, latch the request and go to CMD on the next cycle.
- Requests offered while req_ready=0 are ignored; the requester holds them.
- CMD (6 cycles):
  - CS# low, dq_oe=1.
  - dq_out = CA[47:40], CA[39:32] ... CA[7:0], one byte per cycle.
  - CA fields:
    - CA[47] = ~write
    - CA[46] = 0 (memory space)
    - CA[45] = 1 (linear burst)
    - CA[44:16] = {10'b0, addr[21:3]}
    - CA[15:3] = 0
    - CA[2:0] = addr[2:0]
- LAT: dq_oe=0, lasts 4*LATENCY+8 cycles (default 20).
- WR (2 cycles):
  - dq_oe=1, rwds_oe=1.
  - Byte order: wdata[15:8] then wdata[7:0].
  - rwds_out = ~be[1] then ~be[0] (RWDS high masks the byte).
- RDW: RD_DELAY idle cycles.
- RD (2 cycles):
  - First cycle captures dq_in into rd_data[15:8]; second captures rd_data[7:0].
  - rd_valid pulses on the cycle after the second capture, which is the first REC cycle.
- psram_ck:
  - 0 in INIT, IDLE and REC.
  - Toggles every cycle from CMD through the end of WR/RD, going 1 in the first CMD cycle.
  - The active cycle count is always even, so ck is 0 again when CS# rises.
- REC: CS# high, all OE low for RECOVERY cycles, then IDLE.
- Cycle budget with defaults, handshake at cycle 0:
  - Write: CMD 1-6, LAT 7-26, WR 27-28, REC 29-32, req_ready=1 at cycle 33.
  - Read: CMD 1-6, LAT 7-26, RDW 27-28, RD 29-30, rd_valid at 31, REC 31-34, req_ready=1 at cycle 35.
- Back-to-back requests: a new request is accepted only after REC; there is no pipelining.
- RWDS input is ignored: fixed latency, capture is timed by RD_DELAY.

Test Plan:
- Reset with INIT_CYCLES=16 -> init_done and req_ready rise exactly 16 cycles after reset falls; psram_cs_n=1 and psram_ck=0 throughout.
- Write addr=0x2ABCDE, wdata=0xA55A, be=2'b11 -> CA bytes 0x20,0x05,0x57,0x9B,0x00,0x06 on cycles 1-6; cycle 27 DQ=0xA5, cycle 28 DQ=0x5A, RWDS=0 on both; CS# high at cycle 29; req_ready at cycle 33.
- Write with be=2'b01 -> rwds_out=1 on cycle 27, 0 on cycle 28, rwds_oe=1 only on cycles 27-28.
- Read addr=0x000001 with a memory model driving 0x12 at cycle 29 and 0x34 at cycle 30 -> CA[47:40]=0xA0, CA[7:0]=0x01; rd_valid pulses once at cycle 31 with rd_data=0x1234.
- req_valid held during a transaction -> request not accepted until req_ready returns; exactly one CMD sequence per handshake; psram_ck=0 whenever psram_cs_n=1.
- Assert reset during LAT of a read -> next cycle CS#=1, dq_oe=0, no rd_valid pulse; full INIT wait is repeated before req_ready returns.
